// File: rtl/controlador_minado.sv
// controlador_minado
//   Sequences a nonce search over an external hash core. Each attempt pulses
//   core_start with the current nonce, waits a bounded number of cycles for
//   core_done, then compares the returned hash_hi against target. The search
//   ends on a passing hash (found), after MAX_TRIES failures (exhausted), or
//   when the core does not answer in time (timeout).
//
// Ports
//   clk          in   1   rising-edge clock
//   reset        in   1   asynchronous active-high reset
//   start        in   1   begin a search (accepted only in IDLE or DONE)
//   abort        in   1   cancel a running search; also blocks start
//   target       in  24   a hash passes when hash_hi < target (unsigned)
//   core_done    in   1   hash core completion pulse, hash_hi valid with it
//   hash_hi      in  24   top 24 bits of the hash result
//   core_start   out  1   one-cycle launch pulse to the hash core
//   nonce        out 32   nonce presented to the hash core
//   busy         out  1   high in LAUNCH, WAIT and CHECK
//   found        out  1   search ended with a passing hash
//   exhausted    out  1   search ended after MAX_TRIES failing hashes
//   timeout      out  1   search ended because core_done never arrived
//   fin          out  1   high while in DONE
//   result_nonce out 32   winning nonce, valid while found=1
//   tries        out 16   attempts completed in the current or last search

module controlador_minado #(
    parameter logic [31:0] NONCE_INIT = 32'h80a9d9e7,
    parameter logic [31:0] NONCE_STEP = 32'h234b724a,
    parameter logic [15:0] MAX_TRIES  = 16'd1000,
    parameter logic [7:0]  TIMEOUT    = 8'd255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [23:0] target,
    input  logic        core_done,
    input  logic [23:0] hash_hi,
    output logic        core_start,
    output logic [31:0] nonce,
    output logic        busy,
    output logic        found,
    output logic        exhausted,
    output logic        timeout,
    output logic        fin,
    output logic [31:0] result_nonce,
    output logic [15:0] tries
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]  state_q,      state_d;
    logic [31:0] nonce_q,      nonce_d;
    logic [15:0] tries_q,      tries_d;
    logic        found_q,      found_d;
    logic        exhausted_q,  exhausted_d;
    logic        timeout_q,    timeout_d;
    logic [31:0] result_q,     result_d;
    logic [23:0] hash_q,       hash_d;
    logic [7:0]  wait_cnt_q,   wait_cnt_d;
    logic        core_start_q, core_start_d;
    logic        busy_q,       busy_d;
    logic        fin_q,        fin_d;

    logic [7:0]  wait_elapsed_s;
    logic [15:0] tries_inc_s;
    logic        hash_pass_s;

    // wait_cnt_q counts WAIT cycles already spent; the elapsed count including
    // the current cycle is compared with TIMEOUT, so WAIT lasts at most TIMEOUT
    // cycles and a core_done in the last of them is still accepted.
    assign wait_elapsed_s = wait_cnt_q + 8'd1;
    assign tries_inc_s    = tries_q + 16'd1;
    // target=0 can never pass since nothing is below zero.
    assign hash_pass_s    = (hash_q < target);

    // Search FSM: next state plus nonce/tries/status updates.
    always_comb begin
        state_d     = state_q;
        nonce_d     = nonce_q;
        tries_d     = tries_q;
        found_d     = found_q;
        exhausted_d = exhausted_q;
        timeout_d   = timeout_q;
        result_d    = result_q;
        hash_d      = hash_q;
        wait_cnt_d  = wait_cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start && !abort) begin
                    state_d     = S_LAUNCH;
                    nonce_d     = NONCE_INIT;
                    tries_d     = 16'd0;
                    found_d     = 1'b0;
                    exhausted_d = 1'b0;
                    timeout_d   = 1'b0;
                    result_d    = 32'd0;
                    wait_cnt_d  = 8'd0;
                end else if (start && abort) begin
                    // abort beats start; status flags keep their last value
                    state_d = S_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            S_LAUNCH: begin
                if (abort) begin
                    state_d     = S_IDLE;
                    found_d     = 1'b0;
                    exhausted_d = 1'b0;
                    timeout_d   = 1'b0;
                end else begin
                    state_d    = S_WAIT;
                    wait_cnt_d = 8'd0;
                end
            end
            S_WAIT: begin
                if (abort) begin
                    state_d     = S_IDLE;
                    found_d     = 1'b0;
                    exhausted_d = 1'b0;
                    timeout_d   = 1'b0;
                end else if (core_done) begin
                    state_d = S_CHECK;
                    hash_d  = hash_hi;
                end else if (wait_elapsed_s == TIMEOUT) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_elapsed_s;
                end
            end
            S_CHECK: begin
                if (abort) begin
                    // the attempt is abandoned, so tries is not advanced
                    state_d     = S_IDLE;
                    found_d     = 1'b0;
                    exhausted_d = 1'b0;
                    timeout_d   = 1'b0;
                end else begin
                    tries_d = tries_inc_s;
                    if (hash_pass_s) begin
                        state_d  = S_DONE;
                        found_d  = 1'b1;
                        result_d = nonce_q;
                    end else if (tries_inc_s == MAX_TRIES) begin
                        state_d     = S_DONE;
                        exhausted_d = 1'b1;
                    end else begin
                        state_d = S_LAUNCH;
                        nonce_d = nonce_q + NONCE_STEP;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered flags that follow directly from the state being entered.
    always_comb begin
        core_start_d = (state_d == S_LAUNCH);
        busy_d       = (state_d == S_LAUNCH) || (state_d == S_WAIT) || (state_d == S_CHECK);
        fin_d        = (state_d == S_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            nonce_q      <= NONCE_INIT;
            tries_q      <= 16'd0;
            found_q      <= 1'b0;
            exhausted_q  <= 1'b0;
            timeout_q    <= 1'b0;
            result_q     <= 32'd0;
            hash_q       <= 24'd0;
            wait_cnt_q   <= 8'd0;
            core_start_q <= 1'b0;
            busy_q       <= 1'b0;
            fin_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            nonce_q      <= nonce_d;
            tries_q      <= tries_d;
            found_q      <= found_d;
            exhausted_q  <= exhausted_d;
            timeout_q    <= timeout_d;
            result_q     <= result_d;
            hash_q       <= hash_d;
            wait_cnt_q   <= wait_cnt_d;
            core_start_q <= core_start_d;
            busy_q       <= busy_d;
            fin_q        <= fin_d;
        end
    end

    assign core_start   = core_start_q;
    assign nonce        = nonce_q;
    assign busy         = busy_q;
    assign found        = found_q;
    assign exhausted    = exhausted_q;
    assign timeout      = timeout_q;
    assign fin          = fin_q;
    assign result_nonce = result_q;
    assign tries        = tries_q;

endmodule

// File: tb/tb_controlador_minado.sv
module tb_controlador_minado;

    localparam logic [7:0]  TO     = 8'd6;
    localparam logic [15:0] MT     = 16'd4;
    localparam logic [31:0] INIT_A = 32'h80a9d9e7;
    localparam logic [31:0] STEP_A = 32'h234b724a;
    localparam logic [31:0] INIT_B = 32'hFFFFFFF0;
    localparam logic [31:0] STEP_B = 32'h00000020;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, abort, core_done;
    logic [23:0] target, hash_hi;

    logic        core_start, busy, found, exhausted, timeout, fin;
    logic [31:0] nonce, result_nonce;
    logic [15:0] tries;

    logic        core_start_b, busy_b, found_b, exhausted_b, timeout_b, fin_b;
    logic [31:0] nonce_b, result_nonce_b;
    logic [15:0] tries_b;

    controlador_minado #(.NONCE_INIT(INIT_A), .NONCE_STEP(STEP_A), .MAX_TRIES(MT), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .target(target),
        .core_done(core_done), .hash_hi(hash_hi), .core_start(core_start), .nonce(nonce),
        .busy(busy), .found(found), .exhausted(exhausted), .timeout(timeout), .fin(fin),
        .result_nonce(result_nonce), .tries(tries));

    // Same stimulus, different nonce sequence: exercises the 32-bit wrap.
    controlador_minado #(.NONCE_INIT(INIT_B), .NONCE_STEP(STEP_B), .MAX_TRIES(MT), .TIMEOUT(TO)) dut_b (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .target(target),
        .core_done(core_done), .hash_hi(hash_hi), .core_start(core_start_b), .nonce(nonce_b),
        .busy(busy_b), .found(found_b), .exhausted(exhausted_b), .timeout(timeout_b), .fin(fin_b),
        .result_nonce(result_nonce_b), .tries(tries_b));

    typedef struct {
        logic        found;
        logic        exh;
        logic        tmo;
        logic [15:0] tries;
        logic [31:0] res_a;
        logic [31:0] res_b;
        int          launches;
        int          gap;
    } exp_res_t;

    exp_res_t    exp_res[$];
    logic [63:0] exp_launch[$];
    int          core_lat_q[$];
    logic [23:0] core_hash_q[$];

    logic [23:0] sc_hash [4];
    int          sc_lat  [4];

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=event expected=none", name);
    endtask

    // Hash core model: answers each core_start after the queued latency.
    initial begin : core_model
        int cnt;
        logic [23:0] h;
        cnt = 0;
        h = 24'd0;
        core_done = 1'b0;
        hash_hi = 24'd0;
        forever begin
            @(negedge clk);
            core_done = 1'b0;
            hash_hi = 24'($urandom);
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    core_done = 1'b1;
                    hash_hi = h;
                end
            end
            if (core_start) begin
                if (core_lat_q.size() > 0) begin
                    cnt = core_lat_q.pop_front();
                    h = core_hash_q.pop_front();
                end else begin
                    cnt = 0;
                end
            end
        end
    end

    // Monitor: checks each launch nonce and each search outcome.
    initial begin : monitor
        int cyc, start_cyc, launches;
        logic fin_prev;
        logic [63:0] el;
        exp_res_t r;
        cyc = 0;
        start_cyc = 0;
        launches = 0;
        fin_prev = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (fin && !fin_prev) begin
                if (exp_res.size() == 0) begin
                    unexpected("unexpected_done");
                end else begin
                    r = exp_res.pop_front();
                    check("found", found, r.found);
                    check("exhausted", exhausted, r.exh);
                    check("timeout", timeout, r.tmo);
                    check("tries", tries, r.tries);
                    check("result_nonce", result_nonce, r.res_a);
                    check("busy_done", busy, 0);
                    check("launch_count", launches, r.launches);
                    check("done_latency", cyc - start_cyc, r.gap);
                    check("b_status", {fin_b, found_b, exhausted_b, timeout_b, busy_b},
                          {1'b1, r.found, r.exh, r.tmo, 1'b0});
                    check("b_tries", tries_b, r.tries);
                    check("b_result_nonce", result_nonce_b, r.res_b);
                end
            end
            if (!busy) launches = 0;
            if (core_start) begin
                start_cyc = cyc;
                launches++;
                check("b_core_start", core_start_b, 1);
                if (exp_launch.size() == 0) begin
                    unexpected("unexpected_launch");
                end else begin
                    el = exp_launch.pop_front();
                    check("nonce", nonce, el[63:32]);
                    check("b_nonce", nonce_b, el[31:0]);
                end
            end
            fin_prev = fin;
        end
    end

    task automatic set_sc(input logic [23:0] h0, input int l0, input logic [23:0] h1, input int l1,
                          input logic [23:0] h2, input int l2, input logic [23:0] h3, input int l3);
        sc_hash[0] = h0; sc_lat[0] = l0;
        sc_hash[1] = h1; sc_lat[1] = l1;
        sc_hash[2] = h2; sc_lat[2] = l2;
        sc_hash[3] = h3; sc_lat[3] = l3;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("launch_latency", core_start, 1);
        check("busy_on_launch", busy, 1);
        check("tries_cleared", tries, 0);
        check("flags_cleared", {fin, found, exhausted, timeout}, 0);
        check("result_cleared", result_nonce, 0);
        check("nonce_init", nonce, INIT_A);
    endtask

    // Reference model: walks the attempt list by the search rules and queues
    // every expected launch nonce plus the final outcome, then runs the search.
    task automatic run_search(input logic [23:0] tgt);
        exp_res_t r;
        bit done;
        int k;
        logic [31:0] na, nb;
        r = '{found: 1'b0, exh: 1'b0, tmo: 1'b0, tries: 16'd0, res_a: 32'd0, res_b: 32'd0,
              launches: 0, gap: 0};
        done = 1'b0;
        for (int i = 0; i < int'(MT) && !done; i++) begin
            na = INIT_A + STEP_A * 32'(i);
            nb = INIT_B + STEP_B * 32'(i);
            exp_launch.push_back({na, nb});
            core_hash_q.push_back(sc_hash[i]);
            core_lat_q.push_back(sc_lat[i]);
            r.launches = i + 1;
            r.gap = sc_lat[i] + 2;
            if (sc_lat[i] > int'(TO)) begin
                r.tmo = 1'b1; r.tries = 16'(i); r.gap = int'(TO) + 1; done = 1'b1;
            end else if (sc_hash[i] < tgt) begin
                r.found = 1'b1; r.tries = 16'(i + 1); r.res_a = na; r.res_b = nb; done = 1'b1;
            end else if (i + 1 == int'(MT)) begin
                r.exh = 1'b1; r.tries = MT; done = 1'b1;
            end
        end
        exp_res.push_back(r);
        target = tgt;
        pulse_start();
        k = 0;
        while (!fin && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!fin) begin
            $display("FAIL search_end actual=busy expected=fin within 100 cycles");
            checks++;
            failures++;
        end
        repeat (3) @(negedge clk);
        check("fin_held", fin, 1);
        check("tries_held", tries, r.tries);
        repeat (3) @(negedge clk);
    endtask

    initial begin : stimulus
        logic [23:0] tgt, hv;
        int k;
        reset = 1'b1; start = 1'b0; abort = 1'b0; target = 24'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_flags", {core_start, busy, found, exhausted, timeout, fin}, 0);
        check("reset_result", result_nonce, 0);
        check("reset_tries", tries, 0);
        check("reset_nonce", nonce, INIT_A);
        check("reset_nonce_b", nonce_b, INIT_B);

        // first-try success
        set_sc(24'h000010, 2, 24'h0, 1, 24'h0, 1, 24'h0, 1);
        run_search(24'h000100);
        // third-try success; dut_b wraps FFFFFFF0 -> 00000010
        set_sc(24'hFFFFFF, 1, 24'hFFFFFF, 3, 24'h000000, 2, 24'h0, 1);
        run_search(24'h000100);
        // exhaustion, then restart clears tries
        set_sc(24'hFFFFFF, 1, 24'hFFFFFF, 2, 24'hFFFFFF, 1, 24'h000100, 2);
        run_search(24'h000100);
        // core_done in the final WAIT cycle; hash equal to target fails
        set_sc(24'h800000, int'(TO), 24'h7FFFFF, int'(TO), 24'h0, 1, 24'h0, 1);
        run_search(24'h800000);
        // first attempt times out
        set_sc(24'h000000, int'(TO) + 1, 24'h0, 1, 24'h0, 1, 24'h0, 1);
        run_search(24'h000100);
        // third attempt times out
        set_sc(24'hFFFFFF, 1, 24'hFFFFFF, 2, 24'h000000, int'(TO) + 2, 24'h0, 1);
        run_search(24'hFFFFFF);
        // target 0 never passes
        set_sc(24'h000000, 1, 24'h000000, 2, 24'h000000, 1, 24'h000000, 1);
        run_search(24'h000000);

        for (int s = 0; s < 40; s++) begin
            case ($urandom_range(3, 0))
                0: tgt = 24'h000000;
                1: tgt = 24'hFFFFFF;
                default: tgt = 24'($urandom);
            endcase
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(3, 0) == 0 && tgt != 24'd0)
                    hv = 24'($urandom_range({8'h00, tgt} - 32'd1, 32'd0));
                else
                    hv = 24'($urandom_range(32'h00FFFFFF, {8'h00, tgt}));
                sc_hash[i] = hv;
                if ($urandom_range(9, 0) == 0)
                    sc_lat[i] = int'(TO) + 1 + int'($urandom_range(2, 0));
                else
                    sc_lat[i] = int'($urandom_range(int'(TO), 1));
            end
            run_search(tgt);
        end

        // abort mid-WAIT of the second attempt: nonce and tries hold
        exp_launch.push_back({INIT_A, INIT_B});
        exp_launch.push_back({INIT_A + STEP_A, INIT_B + STEP_B});
        core_hash_q.push_back(24'hFFFFFF); core_lat_q.push_back(1);
        core_hash_q.push_back(24'h000000); core_lat_q.push_back(int'(TO) + 3);
        target = 24'h000100;
        pulse_start();
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!core_start && k < 20);
        check("second_launch_seen", core_start, 1);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_flags", {core_start, busy, found, exhausted, timeout, fin}, 0);
        check("abort_tries_hold", tries, 1);
        check("abort_nonce_hold", nonce, INIT_A + STEP_A);
        check("abort_nonce_b_hold", nonce_b, INIT_B + STEP_B);
        repeat (12) @(negedge clk);
        check("idle_ignores_core_done", {busy, fin, found}, 0);

        // abort beats start in IDLE
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("abort_over_start", {core_start, busy}, 0);
        repeat (2) @(negedge clk);
        check("abort_over_start_idle", busy, 0);

        // asynchronous reset mid-WAIT of the second attempt
        exp_launch.push_back({INIT_A, INIT_B});
        exp_launch.push_back({INIT_A + STEP_A, INIT_B + STEP_B});
        core_hash_q.push_back(24'hFFFFFF); core_lat_q.push_back(1);
        core_hash_q.push_back(24'h000000); core_lat_q.push_back(int'(TO) + 3);
        pulse_start();
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!core_start && k < 20);
        @(negedge clk);
        check("busy_before_reset", busy, 1);
        #2 reset = 1'b1;
        #1;
        check("async_reset_flags", {core_start, busy, found, exhausted, timeout, fin}, 0);
        check("async_reset_tries", tries, 0);
        check("async_reset_nonce", nonce, INIT_A);
        check("async_reset_nonce_b", nonce_b, INIT_B);
        check("async_reset_result", result_nonce, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        check("no_start_after_reset", {busy, core_start, fin}, 0);

        check("launch_queue_empty", exp_launch.size(), 0);
        check("result_queue_empty", exp_res.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/controlador_minado.md
CONTROLADOR_MINADO -- requirements
Module: controlador_minado

Interface
REQ-001 SHALL have parameter NONCE_INIT, default 32'h80a9d9e7, first nonce of each search.
REQ-002 SHALL have parameter NONCE_STEP, default 32'h234b724a, increment between successive nonces.
REQ-003 SHALL have parameter MAX_TRIES, default 16'd1000, attempts per search; legal range 1..65535.
REQ-004 SHALL have parameter TIMEOUT, default 8'd255, max cycles to wait for core_done per attempt; legal range 1..255.
REQ-005 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port start  input  1  begin a search when sampled high in IDLE or DONE.
REQ-008 SHALL have port abort  input  1  cancel a search in progress.
REQ-009 SHALL have port target  input  24  difficulty threshold; a hash passes when hash_hi < target, unsigned.
REQ-010 SHALL have port core_done  input  1  one-cycle pulse from hash core; hash_hi valid in the same cycle.
REQ-011 SHALL have port hash_hi  input  24  top 24 bits of the core's hash result.
REQ-012 SHALL have port core_start  output  1  one-cycle pulse launching the hash core.
REQ-013 SHALL have port nonce  output  32  nonce for the hash core; stable from core_start until leaving WAIT.
REQ-014 SHALL have port busy, found, exhausted, timeout, fin  output  1 each  status flags.
REQ-015 SHALL have port result_nonce  output  32  winning nonce, valid while found=1.
REQ-016 SHALL have port tries  output  16  attempts completed in the current or last search.

Function
REQ-017 SHALL drive all outputs from registers.
REQ-018 SHALL implement FSM states IDLE, LAUNCH, WAIT, CHECK, DONE; busy=1 exactly in LAUNCH, WAIT and CHECK.
REQ-019 SHALL, in IDLE or DONE with start=1 and abort=0, load nonce=NONCE_INIT, clear tries, found, exhausted, timeout, fin and result_nonce, then go to LAUNCH.
REQ-020 SHALL assert core_start for exactly the one cycle spent in LAUNCH, then go to WAIT; core_start is high the cycle after start is sampled.
REQ-021 SHALL, in WAIT, count cycles from 0; on core_done=1, capture hash_hi and go to CHECK.
REQ-022 SHALL, in WAIT, set timeout=1 and go to DONE when the counter reaches TIMEOUT with core_done=0; core_done in that same cycle takes priority.
REQ-023 SHALL, in CHECK, increment tries by 1.
REQ-024 SHALL, in CHECK, if captured hash < target: set found=1, result_nonce=nonce, go to DONE.
REQ-025 SHALL, in CHECK, if the hash fails and the new tries equals MAX_TRIES: set exhausted=1, go to DONE.
REQ-026 SHALL, in CHECK, otherwise set nonce=nonce+NONCE_STEP mod 2^32 (wrap, no carry out) and go to LAUNCH.
REQ-027 SHALL assert fin=1 in DONE and hold every status output until the next accepted start or reset.
REQ-028 SHALL ignore start while busy=1, and ignore core_done outside WAIT.
REQ-029 SHALL, on abort=1 in LAUNCH, WAIT or CHECK, go to IDLE next cycle with core_start=0 and fin, found, exhausted, timeout=0; tries and nonce hold.
REQ-030 SHALL let abort win over start when both are high in IDLE or DONE; the FSM goes to or stays in IDLE.
REQ-031 SHALL treat target=0 as never passing, so the search ends in exhausted or timeout.

Reset
REQ-032 SHALL, on reset=1 at any time including mid-search, immediately set: state=IDLE, nonce=NONCE_INIT, core_start, busy, found, exhausted, timeout, fin=0, result_nonce=0, tries=0.
REQ-033 SHALL leave IDLE only on a start sampled after reset deasserts.

Verification
REQ-034 SHALL cover first-try success: target=24'h000100, core returns hash_hi=24'h000010 -> found=1, fin=1, result_nonce=32'h80a9d9e7, tries=1.
REQ-035 SHALL cover third-try success: first two hashes 24'hFFFFFF, third 24'h000000 -> result_nonce=32'hC740BE7B, tries=3, core_start pulsed 3 times.
REQ-036 SHALL cover wrap: NONCE_INIT=32'hFFFFFFF0, NONCE_STEP=32'h20, first hash fails -> second nonce=32'h00000010.
REQ-037 SHALL cover exhaustion: MAX_TRIES=4, every hash fails -> exhausted=1, found=0, tries=4, fin=1, then start restarts with tries=0.
REQ-038 SHALL cover timeout: core_done never asserted -> timeout=1, fin=1, tries=0, TIMEOUT+1 cycles after core_start; a core_done in the final WAIT cycle gives CHECK instead.
REQ-039 SHALL cover abort and reset mid-WAIT: abort -> IDLE with fin=0; reset asserted asynchronously -> all outputs at REQ-032 values before the next clk edge.
